// File: rtl/lif_neuron_core.sv
// lif_neuron_core
//   Leaky integrate-and-fire membrane update stage. It sits around an external
//   shift-and-add decay unit. The stage holds the membrane potential and drives
//   the decay unit with the potential taps and the two mux selects. It registers
//   the decayed value that comes back, adds the input current, and compares the
//   result against the threshold. It emits one spike decision for each accepted
//   current sample.
//
// Configuration macro:
//   LIF_RESET_TO_ZERO_EN  defined   -> a spike clears the potential to 0
//                         undefined -> a spike subtracts the threshold (default)
//
// Parameters:
//   REFRACT_CYCLES  cycles cur_ready stays low after a spike (0 = none)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cur_valid/cur_ready         current sample handshake
//   current, threshold          8-bit unsigned sample and firing threshold
//   beta_sel                    decay factor select (9..15 decode as 1.0)
//   potential, potential_1..3   membrane register and its >>1, >>2, >>3 taps
//   cntrl1, cntrl2              decay-unit pre-add / output mux selects
//   mult_ans                    decayed potential from the decay unit
//   spike_valid, spike          one-cycle decision pulse and fire flag
//
// State table:
//   IDLE    | ready for a sample, latches current/threshold/beta_sel
//   DECAY   | decay unit driven, decayed potential registered
//   INTEG   | add current, saturate, compare, update potential
//   REFRACT | refractory hold, potential frozen

module lif_neuron_core #(
    parameter int REFRACT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cur_valid,
    output logic       cur_ready,
    input  logic [7:0] current,
    input  logic [7:0] threshold,
    input  logic [3:0] beta_sel,
    output logic [7:0] potential,
    output logic [7:0] potential_1,
    output logic [7:0] potential_2,
    output logic [7:0] potential_3,
    output logic [3:0] cntrl1,
    output logic [3:0] cntrl2,
    input  logic [7:0] mult_ans,
    output logic       spike_valid,
    output logic       spike
);

    typedef enum logic [1:0] {IDLE, DECAY, INTEG, REFRACT} state_t;

    state_t     state;
    logic [7:0] cur_q;
    logic [7:0] thr_q;
    logic [7:0] decayed;
    logic [7:0] pot_q;
    logic [3:0] refr_cnt;
    logic [8:0] sum_raw;
    logic [7:0] sum_sat;
    logic       fire;

    // Returns {cntrl1, cntrl2}. Reserved codes map to unity gain, so the
    // decay unit never receives a select it does not decode.
    function automatic logic [7:0] decode_beta(input logic [3:0] b);
        logic [7:0] r;
        case (b)
            4'd0:    r = {4'd0, 4'd0};
            4'd1:    r = {4'd0, 4'd1};
            4'd2:    r = {4'd0, 4'd2};
            4'd3:    r = {4'd0, 4'd3};
            4'd4:    r = {4'd0, 4'd4};
            4'd5:    r = {4'd0, 4'd5};
            4'd6:    r = {4'd1, 4'd6};
            4'd7:    r = {4'd0, 4'd6};
            4'd8:    r = {4'd2, 4'd6};
            default: r = {4'd0, 4'd1};
        endcase
        return r;
    endfunction

    assign potential   = pot_q;
    assign potential_1 = {1'b0, pot_q[7:1]};
    assign potential_2 = {2'b0, pot_q[7:2]};
    assign potential_3 = {3'b0, pot_q[7:3]};

    always_comb begin
        sum_raw = {1'b0, decayed} + {1'b0, cur_q};
        sum_sat = sum_raw[8] ? 8'hFF : sum_raw[7:0];
        fire    = (sum_sat >= thr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pot_q       <= '0;
            cur_q       <= '0;
            thr_q       <= '0;
            decayed     <= '0;
            refr_cnt    <= '0;
            cntrl1      <= '0;
            cntrl2      <= '0;
            spike_valid <= 1'b0;
            spike       <= 1'b0;
            cur_ready   <= 1'b1;
        end else begin
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cur_valid) begin
                        cur_q             <= current;
                        thr_q             <= threshold;
                        // Selects are registered here so they are stable for
                        // the whole DECAY cycle.
                        {cntrl1, cntrl2}  <= decode_beta(beta_sel);
                        cur_ready         <= 1'b0;
                        state             <= DECAY;
                    end
                end
                DECAY: begin
                    decayed <= mult_ans;
                    cntrl1  <= 4'd0;
                    cntrl2  <= 4'd1;
                    state   <= INTEG;
                end
                INTEG: begin
                    spike_valid <= 1'b1;
                    spike       <= fire;
                    if (fire) begin
`ifdef LIF_RESET_TO_ZERO_EN
                        pot_q <= '0;
`else
                        pot_q <= sum_sat - thr_q;
`endif
                        if (REFRACT_CYCLES == 0) begin
                            cur_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            refr_cnt <= 4'(REFRACT_CYCLES - 1);
                            state    <= REFRACT;
                        end
                    end else begin
                        pot_q     <= sum_sat;
                        cur_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                REFRACT: begin
                    if (refr_cnt == 4'd0) begin
                        cur_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        refr_cnt <= refr_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_core.sv
module tb_lif_neuron_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       cur_valid;
    logic       cur_ready;
    logic [7:0] current;
    logic [7:0] threshold;
    logic [3:0] beta_sel;
    logic [7:0] potential, potential_1, potential_2, potential_3;
    logic [3:0] cntrl1, cntrl2;
    logic [7:0] mult_ans;
    logic       spike_valid, spike;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] obs_c1, obs_c2;
    logic       obs_spk;
    logic [7:0] obs_pot;

    always #5 clk = ~clk;

    lif_neuron_core #(.REFRACT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cur_valid(cur_valid), .cur_ready(cur_ready),
        .current(current), .threshold(threshold), .beta_sel(beta_sel),
        .potential(potential), .potential_1(potential_1),
        .potential_2(potential_2), .potential_3(potential_3),
        .cntrl1(cntrl1), .cntrl2(cntrl2), .mult_ans(mult_ans),
        .spike_valid(spike_valid), .spike(spike)
    );

    // Decay unit model: the factor selected by {cntrl1, cntrl2} is built from the taps.
    always_comb begin
        case ({cntrl1, cntrl2})
            8'h00:   mult_ans = 8'd0;
            8'h01:   mult_ans = potential;
            8'h02:   mult_ans = potential_1;
            8'h03:   mult_ans = potential_2;
            8'h04:   mult_ans = potential_3;
            8'h05:   mult_ans = potential_1 + potential_2;
            8'h16:   mult_ans = potential_1 + potential_2 + potential_3;
            8'h06:   mult_ans = potential_1 + potential_3;
            8'h26:   mult_ans = potential_2 + potential_3;
            default: mult_ans = potential;
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge where spike_valid is high.
    task automatic send(input logic [7:0] c, input logic [7:0] t, input logic [3:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!cur_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 0, 1);
        cur_valid = 1'b1; current = c; threshold = t; beta_sel = b;
        @(negedge clk);
        cur_valid = 1'b0;
        obs_c1 = cntrl1;
        obs_c2 = cntrl2;
        n = 1;
        while (!spike_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 3);
        obs_spk = spike;
        obs_pot = potential;
    endtask

    logic exp_hard;
    int   sv_seen;

    initial begin
`ifdef LIF_RESET_TO_ZERO_EN
        exp_hard = 1'b1;
`else
        exp_hard = 1'b0;
`endif
        rst = 1'b1; cur_valid = 1'b0; current = '0; threshold = '0; beta_sel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_potential", potential, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_cur_ready", cur_ready, 1);
        check("rst_cntrl1", cntrl1, 0);
        check("rst_cntrl2", cntrl2, 0);

        // Test 1: beta 0.5, threshold 100
        send(8'd60, 8'd100, 4'd2);
        check("t1_cntrl2", obs_c2, 2);
        check("t1_s1_spike", obs_spk, 0);
        check("t1_s1_pot", obs_pot, 60);
        check("t1_tap1", potential_1, 30);
        check("t1_tap2", potential_2, 15);
        check("t1_tap3", potential_3, 7);
        check("t1_ready_nospike", cur_ready, 1);
        send(8'd60, 8'd100, 4'd2);
        check("t1_s2_spike", obs_spk, 0);
        check("t1_s2_pot", obs_pot, 90);
        send(8'd80, 8'd100, 4'd2);
        check("t1_s3_spike", obs_spk, 1);
        check("t1_s3_pot", obs_pot, exp_hard ? 0 : 25);
        check("t1_refr_ready0", cur_ready, 0);
        @(negedge clk);
        check("t1_refr_ready1", cur_ready, 0);
        check("t1_refr_sv", spike_valid, 0);
        check("t1_refr_pot", potential, exp_hard ? 0 : 25);
        @(negedge clk);
        check("t1_refr_ready2", cur_ready, 1);

        // Test 2: beta 6/7/8 from potential 64
        send(8'd64, 8'd255, 4'd0);
        check("t2_load", obs_pot, 64);
        send(8'd0, 8'd255, 4'd6);
        check("t2_b6_c1", obs_c1, 1);
        check("t2_b6_c2", obs_c2, 6);
        check("t2_b6_pot", obs_pot, 56);
        check("t2_b6_spike", obs_spk, 0);
        check("t2_hold_c2", cntrl2, 1);
        send(8'd64, 8'd255, 4'd0);
        send(8'd0, 8'd255, 4'd7);
        check("t2_b7_c1", obs_c1, 0);
        check("t2_b7_c2", obs_c2, 6);
        check("t2_b7_pot", obs_pot, 40);
        send(8'd64, 8'd255, 4'd0);
        send(8'd0, 8'd255, 4'd8);
        check("t2_b8_c1", obs_c1, 2);
        check("t2_b8_c2", obs_c2, 6);
        check("t2_b8_pot", obs_pot, 24);

        // Test 3: saturation
        send(8'd200, 8'd255, 4'd0);
        check("t3_load", obs_pot, 200);
        send(8'd100, 8'd255, 4'd1);
        check("t3_spike", obs_spk, 1);
        check("t3_pot", obs_pot, 0);

        // Test 6: zero threshold, reserved beta
        send(8'd7, 8'd0, 4'd0);
        check("t6_spike", obs_spk, 1);
        check("t6_pot", obs_pot, exp_hard ? 0 : 7);
        send(8'd0, 8'd255, 4'd12);
        check("t6_b12_c1", obs_c1, 0);
        check("t6_b12_c2", obs_c2, 1);
        check("t6_b12_pot", obs_pot, exp_hard ? 0 : 7);
        check("t6_b12_spike", obs_spk, 0);

        // Test 5: reset during DECAY
        send(8'd50, 8'd255, 4'd1);
        check("t5_pre_pot", obs_pot, exp_hard ? 50 : 57);
        @(negedge clk);
        cur_valid = 1'b1; current = 8'd100; threshold = 8'd1; beta_sel = 4'd1;
        @(negedge clk);
        cur_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", cur_ready, 1);
        check("t5_pot", potential, 0);
        sv_seen = 0;
        repeat (5) begin
            if (spike_valid) sv_seen++;
            @(negedge clk);
        end
        check("t5_no_spike_valid", sv_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
